cipher_out_buffer: RTL
======================

# cipher_out_buffer

Elastic buffer directly downstream of the stream cipher stage. It captures every ciphertext byte the cipher emits on its dout/dout_valid pair, which has no backpressure, and re-presents the bytes to the consumer over a ready/valid handshake. It raises almost_full early enough for the upstream sequencer to pause din_valid. Bytes lost to overflow are flagged with a sticky bit, never silently.

## Interface
- DEPTH, 16, buffer entries; power of two, ≥ 4
- AFULL_THRESH, DEPTH-2, occupancy at or above which almost_full asserts; 1 ≤ AFULL_THRESH ≤ DEPTH
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  8  ciphertext byte (cipher dout)
- in_valid  input  1  in_data valid this cycle (cipher dout_valid)
- clear  input  1  synchronous flush
- out_data  output  8  head-of-buffer byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_full  output  1  count ≥ AFULL_THRESH
- overflow  output  1  sticky: a byte was dropped
- byte_cnt  output  16  total bytes accepted since reset/clear

## Operation
- push = in_valid && (!full || pop); pop = out_valid && out_ready.
- Push writes in_data at wr_ptr and increments wr_ptr. Pop increments rd_ptr. Both pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count next = count + push − pop. Push and pop together leave count unchanged.
- The buffer is first-word-fall-through: out_data = mem[rd_ptr] combinationally, out_valid = !empty.
- out_data is don't-care while out_valid is low. The bench checks it only when out_valid is high.
- No empty bypass: a byte written at edge t appears on out_valid after edge t. If in_valid and out_ready are both high while empty, the byte is stored and not popped.
- Full with no pop and in_valid high: the byte is dropped, overflow sets to 1, count and byte_cnt are unchanged.
- Full with pop and in_valid high: push and pop both occur, no overflow.
- byte_cnt increments by 1 on every push and wraps 16'hFFFF → 16'h0000.
- clear has priority over push and pop in the same cycle. It zeroes the pointers, count, overflow and byte_cnt. A coincident in_valid byte is discarded and does not count as overflow. Memory contents are not cleared.
- overflow is cleared only by clear or reset.
- The consumer may hold out_ready high permanently or toggle it freely. The block never requires out_ready before asserting out_valid.

## Timing
- Reset values: count 0, empty 1, full 0, almost_full 0, out_valid 0, overflow 0, byte_cnt 0, pointers 0. out_data is don't-care.
- Reset can assert asynchronously mid-stream. All held bytes are discarded, outputs take reset values immediately, and the first edge after deassertion behaves as a normal cycle.
- Input-to-output latency is 1 cycle when empty, otherwise count cycles of pops ahead.
- empty, full, almost_full and count are all registered or derived from registered count, with no combinational path from in_valid. out_valid has no combinational path from out_ready.
- Throughput: 1 byte/cycle sustained when out_ready is held high.
- The upstream sequencer must drop din_valid within DEPTH − AFULL_THRESH cycles of almost_full rising, to absorb the cipher's 1-cycle pipeline plus 1 cycle of reaction.

## Structure
- Shared package cipher_pkg:
  - typedef byte_t (logic [7:0]), used by in_data and out_data
  - constant CIPHER_BUF_DEPTH_DEFAULT = 16
  - constant BYTE_CNT_W = 16
- One sub-module, cipher_buf_mem: DEPTH × byte_t register array with one synchronous write port and one asynchronous read port, no reset on storage.
- Pointer, count and flag logic, overflow and byte_cnt stay in cipher_out_buffer.

## Test plan
- Reset, then push 8'h3C, 8'hA5, 8'h00 on consecutive cycles with out_ready=0. Expect count=3, out_data=8'h3C, byte_cnt=3. Then set out_ready=1 and expect 3C, A5, 00 in order, then empty=1.
- Push 16 bytes (0x00..0x0F) with out_ready=0. Expect almost_full at count=14, full at 16. Push 8'hFF as a 17th byte: overflow=1, count=16, byte_cnt=16. Drain: data 0x00..0x0F, 8'hFF absent.
- At full, hold in_valid=1 and out_ready=1 for 40 cycles with incrementing data. Expect count=16 throughout, overflow=0, pointer wrap, output strictly in order.
- Assert clear together with in_valid (8'h77) at count=5 and overflow=1. Expect count=0, empty=1, overflow=0, byte_cnt=0 next cycle, and 8'h77 never output.
- Push 65537 bytes through with out_ready=1. Expect byte_cnt=1 after wrap. Assert rst_n low asynchronously mid-cycle at count=7: all outputs return to reset values before the next edge.
- Random in_valid (70%) and out_ready (50%) for 10k cycles against a scoreboard model. Expect an exact data match, count consistency, and overflow asserted only on modelled drops.

Source files
------------

// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cipher_pkg
// Description : Shared types and constants for the cipher output datapath.
//               byte_t                   - one ciphertext byte
//               CIPHER_BUF_DEPTH_DEFAULT - default elastic buffer depth
//               BYTE_CNT_W               - width of the accepted-byte counter
// Revision    : 1.0 - initial release
// ============================================================================
package cipher_pkg;

  typedef logic [7:0] byte_t;

  localparam int CIPHER_BUF_DEPTH_DEFAULT = 16;
  localparam int BYTE_CNT_W               = 16;

endpackage : cipher_pkg
`default_nettype wire

// File: rtl/cipher_buf_mem.sv
`default_nettype none
// ============================================================================
// Module      : cipher_buf_mem
// Description : DEPTH x byte_t register array, one synchronous write port and
//               one asynchronous read port. Storage has no reset.
// Ports       : clk     - clock, write on rising edge
//               wr_en   - write enable
//               wr_addr - write address
//               wr_data - write byte
//               rd_addr - read address
//               rd_data - byte at rd_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_buf_mem
  import cipher_pkg::*;
#(
  parameter int DEPTH = CIPHER_BUF_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  byte_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output byte_t         rd_data
);

  byte_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : cipher_buf_mem
`default_nettype wire

// File: rtl/cipher_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cipher_out_buffer
// Description : First-word-fall-through elastic buffer behind the stream
//               cipher. Captures every valid ciphertext byte (no upstream
//               backpressure), presents it over ready/valid, warns early via
//               almost_full and flags dropped bytes with a sticky overflow.
// Ports       : clk, rst_n         - clock / async active-low reset
//               in_data, in_valid  - cipher byte stream
//               clear              - synchronous flush (highest priority)
//               out_data/valid/ready - consumer handshake
//               count, empty, full, almost_full - occupancy status
//               overflow           - sticky dropped-byte flag
//               byte_cnt           - bytes accepted since reset/clear
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_out_buffer
  import cipher_pkg::*;
#(
  parameter int DEPTH        = CIPHER_BUF_DEPTH_DEFAULT,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  byte_t                      in_data,
  input  logic                       in_valid,
  input  logic                       clear,
  output byte_t                      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [BYTE_CNT_W-1:0]      byte_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(AFULL_THRESH);

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;

  // All status flags come from the registered count only, so nothing on the
  // output side has a combinational path from in_valid or out_ready.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);

  assign w_pop  = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full buffer can still
  // accept when the consumer is draining.
  assign w_push = in_valid && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_byte_cnt <= '0;
    end else if (clear) begin
      // Flush wins over any coincident push/pop; a byte arriving now is
      // discarded without being counted as overflow.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  cipher_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push && !clear),
    .wr_addr (r_wr_ptr),
    .wr_data (in_data),
    .rd_addr (r_rd_ptr),
    .rd_data (out_data)
  );

  assign out_valid   = !w_empty;
  assign count       = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= C_AFULL);
  assign overflow    = r_overflow;
  assign byte_cnt    = r_byte_cnt;

endmodule : cipher_out_buffer
`default_nettype wire
